// File: rtl/synth_pkg.sv
// Shared constants and the scheduler state encoding for the synth voice path.
package synth_pkg;
    localparam logic [1:0] EV_NOTE_OFF = 2'd0;
    localparam logic [1:0] EV_NOTE_ON  = 2'd1;
    localparam logic [1:0] EV_ALL_OFF  = 2'd2;
    localparam logic [7:0] KEY_NONE    = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        SCAN_ON,
        SCAN_OFF,
        STEAL_OFF,
        ISSUE_ON,
        ALLOFF
    } sched_state_t;
endpackage

// File: rtl/voice_scheduler_if.sv
// Decoder event channel (valid/ready) plus the one-cycle key update strobe to the synth engine.
interface voice_scheduler_if #(parameter int V_WIDTH = 3);
    logic               ev_valid;
    logic               ev_ready;
    logic [1:0]         ev_type;
    logic [6:0]         ev_key;
    logic [6:0]         ev_vel;
    logic               upd_valid;
    logic [V_WIDTH-1:0] upd_voice;
    logic               upd_on;
    logic [7:0]         upd_key;
    logic [7:0]         upd_vel;

    modport master (
        output ev_valid, ev_type, ev_key, ev_vel,
        input  ev_ready, upd_valid, upd_voice, upd_on, upd_key, upd_vel
    );

    modport slave (
        input  ev_valid, ev_type, ev_key, ev_vel,
        output ev_ready, upd_valid, upd_voice, upd_on, upd_key, upd_vel
    );
endinterface

// File: rtl/voice_age_tracker.sv
// Per-voice age counters, one-cycle update: chosen voice clears, other gated voices count up and saturate.
// No backpressure; counters only move when upd is pulsed.
module voice_age_tracker #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            upd,
    input  logic [V_WIDTH-1:0]              sel,
    input  logic [VOICES-1:0]               gate,
    output logic [VOICES-1:0][V_WIDTH:0]    age
);
    localparam logic [V_WIDTH:0] AGE_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (upd) begin
            for (int v = 0; v < VOICES; v++) begin
                if (V_WIDTH'(v) == sel)
                    age[v] <= '0;
                else if (gate[v] && age[v] != AGE_MAX)
                    age[v] <= age[v] + 1'b1;
            end
        end
    end
endmodule

// File: rtl/voice_scheduler.sv
// Voice allocator: one voice scanned per clock; note on strobes at accept+VOICES+1 (steal: off then on).
// ev_ready is high only while idle, so the decoder is held off for the whole scan.
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
) (
    input  logic                CLOCK_25,
    input  logic                reset_reg_N,
    voice_scheduler_if.slave    bus,
    input  logic [VOICES-1:0]   voice_free,
    output logic [VOICES-1:0]   keys_on,
    output logic [V_WIDTH:0]    active_keys,
    output logic                busy
);
    localparam logic [V_WIDTH:0] AK_MAX = (V_WIDTH+1)'(VOICES);

    sched_state_t               state, state_nxt;
    logic [V_WIDTH-1:0]         idx, sel_idx;
    logic [6:0]                 key_r, vel_r;
    logic                       retrig;
    logic [VOICES-1:0][7:0]     key_val;
    logic [VOICES-1:0]          vf_meta, vf_s;
    logic [VOICES-1:0][V_WIDTH:0] ages;

    logic                       m_fnd, f_fnd, r_fnd, o_fnd;
    logic                       m_fnd_n, f_fnd_n, r_fnd_n, o_fnd_n;
    logic [V_WIDTH-1:0]         m_idx, f_idx, r_idx, o_idx;
    logic [V_WIDTH-1:0]         m_idx_n, f_idx_n, r_idx_n, o_idx_n;
    logic [V_WIDTH:0]           r_age, o_age, r_age_n, o_age_n;
    logic                       scan_last;
    logic [V_WIDTH-1:0]         pick_idx;

    logic                       fire_d, on_d;
    logic [V_WIDTH-1:0]         voice_d;
    logic [7:0]                 key_d, vel_d;

    assign scan_last    = (idx == V_WIDTH'(VOICES-1));
    assign bus.ev_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    voice_age_tracker #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) u_age (
        .clk   (CLOCK_25),
        .rst_n (reset_reg_N),
        .upd   (state == ISSUE_ON),
        .sel   (sel_idx),
        .gate  (keys_on),
        .age   (ages)
    );

    // Candidate tracking folds in the voice at idx; the final-cycle decision uses these _n values.
    always_comb begin
        m_fnd_n = m_fnd; m_idx_n = m_idx;
        f_fnd_n = f_fnd; f_idx_n = f_idx;
        r_fnd_n = r_fnd; r_idx_n = r_idx; r_age_n = r_age;
        o_fnd_n = o_fnd; o_idx_n = o_idx; o_age_n = o_age;
        if (keys_on[idx]) begin
            if (!m_fnd && key_val[idx] == {1'b0, key_r}) begin
                m_fnd_n = 1'b1; m_idx_n = idx;
            end
            if (!o_fnd || ages[idx] > o_age) begin
                o_fnd_n = 1'b1; o_idx_n = idx; o_age_n = ages[idx];
            end
        end else begin
            if (!f_fnd && vf_s[idx]) begin
                f_fnd_n = 1'b1; f_idx_n = idx;
            end
            if (!r_fnd || ages[idx] > r_age) begin
                r_fnd_n = 1'b1; r_idx_n = idx; r_age_n = ages[idx];
            end
        end
        pick_idx = m_fnd_n ? m_idx_n : f_fnd_n ? f_idx_n : r_fnd_n ? r_idx_n : o_idx_n;
    end

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.ev_valid) begin
                case (bus.ev_type)
                    EV_NOTE_ON:  state_nxt = (bus.ev_vel != 7'd0) ? SCAN_ON : SCAN_OFF;
                    EV_NOTE_OFF: state_nxt = SCAN_OFF;
                    EV_ALL_OFF:  state_nxt = ALLOFF;
                    default:     state_nxt = IDLE;
                endcase
            end
            SCAN_ON:   if (scan_last) state_nxt = (m_fnd_n || f_fnd_n || r_fnd_n) ? ISSUE_ON : STEAL_OFF;
            SCAN_OFF:  if (scan_last) state_nxt = IDLE;
            ALLOFF:    if (scan_last) state_nxt = IDLE;
            STEAL_OFF: state_nxt = ISSUE_ON;
            ISSUE_ON:  state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fire_d  = 1'b0;
        on_d    = 1'b0;
        voice_d = '0;
        key_d   = KEY_NONE;
        vel_d   = 8'd0;
        case (state)
            STEAL_OFF: begin
                fire_d = 1'b1; voice_d = sel_idx;
            end
            ISSUE_ON: begin
                fire_d = 1'b1; on_d = 1'b1; voice_d = sel_idx;
                key_d  = {1'b0, key_r}; vel_d = {1'b0, vel_r};
            end
            SCAN_OFF: if (scan_last && m_fnd_n) begin
                fire_d = 1'b1; voice_d = m_idx_n;
            end
            ALLOFF: if (keys_on[idx]) begin
                fire_d = 1'b1; voice_d = idx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            bus.upd_valid <= 1'b0;
            bus.upd_voice <= '0;
            bus.upd_on    <= 1'b0;
            bus.upd_key   <= KEY_NONE;
            bus.upd_vel   <= 8'd0;
            keys_on       <= '0;
            key_val       <= {VOICES{KEY_NONE}};
            active_keys   <= '0;
            vf_meta       <= '0;
            vf_s          <= '0;
            idx           <= '0;
            sel_idx       <= '0;
            retrig        <= 1'b0;
            key_r         <= '0;
            vel_r         <= '0;
            {m_fnd, f_fnd, r_fnd, o_fnd} <= '0;
            {m_idx, f_idx, r_idx, o_idx} <= '0;
            r_age         <= '0;
            o_age         <= '0;
        end else begin
            vf_meta       <= voice_free;
            vf_s          <= vf_meta;
            bus.upd_valid <= fire_d;
            bus.upd_voice <= voice_d;
            bus.upd_on    <= on_d;
            bus.upd_key   <= key_d;
            bus.upd_vel   <= vel_d;
            if (fire_d) begin
                keys_on[voice_d] <= on_d;
                key_val[voice_d] <= key_d;
            end
            case (state)
                IDLE: begin
                    idx <= '0;
                    {m_fnd, f_fnd, r_fnd, o_fnd} <= '0;
                    if (bus.ev_valid) begin
                        key_r <= bus.ev_key;
                        vel_r <= bus.ev_vel;
                    end
                end
                SCAN_ON, SCAN_OFF: begin
                    idx   <= scan_last ? '0 : idx + 1'b1;
                    m_fnd <= m_fnd_n; m_idx <= m_idx_n;
                    f_fnd <= f_fnd_n; f_idx <= f_idx_n;
                    r_fnd <= r_fnd_n; r_idx <= r_idx_n; r_age <= r_age_n;
                    o_fnd <= o_fnd_n; o_idx <= o_idx_n; o_age <= o_age_n;
                    if (state == SCAN_ON && scan_last) begin
                        sel_idx <= pick_idx;
                        retrig  <= m_fnd_n;
                    end
                end
                ALLOFF: idx <= scan_last ? '0 : idx + 1'b1;
                default: ;
            endcase
            if ((state == STEAL_OFF || (state == SCAN_OFF && fire_d)) && active_keys != '0)
                active_keys <= active_keys - 1'b1;
            else if (state == ISSUE_ON && !retrig && active_keys != AK_MAX)
                active_keys <= active_keys + 1'b1;
            else if (state == ALLOFF && scan_last)
                active_keys <= '0;
        end
    end
endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: directed steps then random events against a voice-allocation reference model.
module tb_voice_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] voice_free;
    logic [7:0] keys_on;
    logic [3:0] active_keys;
    logic       busy;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {int cyc; int voice; int on; int key; int vel;} exp_t;
    exp_t exp_q[$];
    int   m_on[8];
    int   m_key[8];
    int   m_age[8];
    int   m_active;

    voice_scheduler_if #(.V_WIDTH(3)) bus ();

    voice_scheduler #(.VOICES(8), .V_WIDTH(3)) dut (
        .CLOCK_25    (clk),
        .reset_reg_N (rst_n),
        .bus         (bus),
        .voice_free  (voice_free),
        .keys_on     (keys_on),
        .active_keys (active_keys),
        .busy        (busy)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(int c, int v, int on, int k, int vel);
        exp_t e;
        e.cyc = c; e.voice = v; e.on = on; e.key = k; e.vel = vel;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_on[i] = 0; m_key[i] = -1; m_age[i] = 0;
        end
        m_active = 0;
        exp_q.delete();
    endfunction

    function automatic logic [7:0] model_keys();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = (m_on[i] != 0);
        return r;
    endfunction

    // Reference allocation: retrigger > free > released (oldest) > steal oldest gated voice.
    function automatic void model_event(int t, int k, int v, int T, logic [7:0] vf);
        int  sel;
        int  best;
        bit  steal;
        bit  retrig;
        sel = -1; steal = 0; retrig = 0;
        if (t == 1 && v != 0) begin
            for (int i = 0; i < 8; i++)
                if (sel < 0 && m_on[i] != 0 && m_key[i] == k) begin sel = i; retrig = 1; end
            for (int i = 0; i < 8; i++)
                if (sel < 0 && m_on[i] == 0 && vf[i]) sel = i;
            if (sel < 0) begin
                best = -1;
                for (int i = 0; i < 8; i++)
                    if (m_on[i] == 0 && m_age[i] > best) begin best = m_age[i]; sel = i; end
            end
            if (sel < 0) begin
                best = -1; steal = 1;
                for (int i = 0; i < 8; i++)
                    if (m_on[i] != 0 && m_age[i] > best) begin best = m_age[i]; sel = i; end
            end
            if (steal) begin
                push(T + 9, sel, 0, 255, 0);
                m_on[sel] = 0;
                m_active--;
                push(T + 10, sel, 1, k, v);
            end else begin
                push(T + 9, sel, 1, k, v);
            end
            for (int j = 0; j < 8; j++)
                if (j != sel && m_on[j] != 0) m_age[j] = (m_age[j] >= 15) ? 15 : m_age[j] + 1;
            m_age[sel] = 0;
            m_on[sel]  = 1;
            m_key[sel] = k;
            if (!retrig) m_active++;
        end else if (t == 0 || t == 1) begin
            for (int i = 0; i < 8; i++)
                if (sel < 0 && m_on[i] != 0 && m_key[i] == k) sel = i;
            if (sel >= 0) begin
                push(T + 8, sel, 0, 255, 0);
                m_on[sel] = 0; m_key[sel] = -1; m_active--;
            end
        end else if (t == 2) begin
            for (int i = 0; i < 8; i++)
                if (m_on[i] != 0) begin
                    push(T + 1 + i, i, 0, 255, 0);
                    m_on[i] = 0; m_key[i] = -1;
                end
            m_active = 0;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.upd_valid === 1'b1) begin
            check("strobe_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("upd_voice", bus.upd_voice, e.voice);
                check("upd_on", bus.upd_on, e.on);
                check("upd_key", bus.upd_key, e.key);
                check("upd_vel", bus.upd_vel, e.vel);
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_keys_on", keys_on, 0);
        check("rst_active", active_keys, 0);
        check("rst_busy", busy, 0);
        check("rst_ev_ready", bus.ev_ready, 1);
        check("rst_upd_valid", bus.upd_valid, 0);
        check("rst_upd_voice", bus.upd_voice, 0);
        check("rst_upd_on", bus.upd_on, 0);
        check("rst_upd_key", bus.upd_key, 8'hFF);
        check("rst_upd_vel", bus.upd_vel, 0);
    endtask

    task automatic issue(input int t, input int k, input int v, input logic [7:0] vf);
        voice_free = vf;
        step(); step(); step();
        check("ev_ready", bus.ev_ready, 1);
        bus.ev_type  = 2'(t);
        bus.ev_key   = 7'(k);
        bus.ev_vel   = 7'(v);
        bus.ev_valid = 1'b1;
        step();
        bus.ev_valid = 1'b0;
        model_event(t, k, v, cyc, vf);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin step(); n++; end
        check("idle_timeout", busy, 0);
        step(); step();
        check("pending_strobes", exp_q.size(), 0);
        check("keys_on", keys_on, model_keys());
        check("active_keys", active_keys, m_active);
    endtask

    task automatic send(input int t, input int k, input int v, input logic [7:0] vf);
        issue(t, k, v, vf);
        wait_idle();
    endtask

    initial begin
        int r;
        int k;
        bus.ev_valid = 1'b0; bus.ev_type = '0; bus.ev_key = '0; bus.ev_vel = '0;
        voice_free = 8'hFF;
        model_reset();
        repeat (3) step();
        check_reset_vals();
        rst_n = 1'b1;
        step();

        send(1, 60, 100, 8'hFF);
        check("t1_keys_on", keys_on, 8'h01);
        check("t1_active", active_keys, 1);

        send(1, 60, 90, 8'hFF);
        check("retrig_keys_on", keys_on, 8'h01);
        check("retrig_active", active_keys, 1);

        send(1, 60, 0, 8'hFF);
        check("vel0_off_active", active_keys, 0);
        send(0, 61, 0, 8'hFF);

        send(1, 60, 50, 8'hFF);
        send(1, 62, 51, 8'hFF);
        send(1, 64, 52, 8'hFF);
        check("three_on", keys_on, 8'h07);
        send(2, 0, 0, 8'hFF);
        check("alloff_keys_on", keys_on, 8'h00);
        send(2, 0, 0, 8'hFF);

        for (int i = 0; i < 8; i++) send(1, 60 + i, 100, 8'hFF);
        check("full_keys_on", keys_on, 8'hFF);
        send(1, 70, 77, 8'h00);
        check("steal_active", active_keys, 8);
        send(3, 10, 10, 8'h00);

        issue(1, 40, 33, 8'hFF);
        step(); step(); step();
        rst_n = 1'b0;
        #2;
        check_reset_vals();
        model_reset();
        step(); step();
        rst_n = 1'b1;
        repeat (15) step();
        check("post_rst_ready", bus.ev_ready, 1);
        check("post_rst_busy", busy, 0);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 15);
            k = $urandom_range(58, 69);
            if (r <= 8)       send(1, k, $urandom_range(1, 127), 8'($urandom));
            else if (r <= 12) send(0, k, $urandom_range(0, 127), 8'($urandom));
            else if (r == 13) send(1, k, 0, 8'($urandom));
            else if (r == 14) send(2, k, 0, 8'($urandom));
            else              send(3, k, $urandom_range(0, 127), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
Allocates synth voices to decoded MIDI note events and sequences key-state updates to the synth engine.
- Sits between the MIDI decoder (event source) and the synth engine (voice_free source, key update sink).
- Owns the per-voice key_on/key_val/age state and implements free-voice search, same-key retrigger and oldest-voice stealing.
- All work is done by a sequential scan FSM, one voice examined per clock.

Parameters:
VOICES, 8, number of voice slots
V_WIDTH, 3, log2(VOICES), voice index width

Ports:
CLOCK_25  in  1  system clock
reset_reg_N  in  1  reset, asynchronous, active-low
ev_valid  in  1  event offered by decoder
ev_ready  out  1  scheduler can accept event
ev_type  in  2  0=note off, 1=note on, 2=all notes off, 3=ignored
ev_key  in  7  MIDI key number
ev_vel  in  7  MIDI velocity
voice_free  in  VOICES  engine: voice envelope finished (asynchronous domain)
keys_on  out  VOICES  gate per voice
upd_valid  out  1  one-cycle key update strobe
upd_voice  out  V_WIDTH  voice index of update
upd_on  out  1  1=gate on, 0=gate off
upd_key  out  8  key value; 8'hFF on gate off
upd_vel  out  8  velocity {1'b0,vel}; 0 on gate off
active_keys  out  V_WIDTH+1  number of voices with gate on
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: keys_on=0, key_val[*]=8'hFF, age[*]=0, upd_valid=0, upd_voice=0, upd_on=0, upd_key=8'hFF, upd_vel=0, active_keys=0, busy=0, ev_ready=1, state=IDLE.
- Reset mid-operation aborts any scan immediately; no update strobe is emitted.
- voice_free is double-flopped before use.
- Handshake: ev_ready=1 only in IDLE. An event is accepted on a cycle where ev_valid&&ev_ready. ev_key, ev_vel and ev_type are latched on acceptance; ev_type=3 is dropped with no state change.
- A note on with ev_vel=0 is treated as a note off.
- States: IDLE, SCAN_ON, SCAN_OFF, STEAL_OFF, ISSUE_ON, ALLOFF.
- SCAN_ON runs for exactly VOICES cycles, index i=0..VOICES-1, and tracks the following candidates, lowest index winning ties:
  - match: keys_on[i] && key_val[i]==key.
  - free: !keys_on[i] && voice_free_s[i].
  - released: !keys_on[i], largest age.
  - oldest: keys_on[i], largest age.
- Selection after the scan, in priority order: match (retrigger, no count change), free, released, oldest.
  - match, free and released go to ISSUE_ON.
  - oldest goes to STEAL_OFF.
- STEAL_OFF: one cycle; emits the gate-off strobe for the victim; active_keys decrements; then ISSUE_ON.
- ISSUE_ON: one cycle; emits upd_on=1, upd_key={1'b0,key}, upd_vel; sets keys_on and key_val.
  - Chosen voice: age=0.
  - Every other voice with keys_on=1: age increments, saturating at 2^(V_WIDTH+1)-1.
  - active_keys increments unless the event was a retrigger.
  - Returns to IDLE.
- Latency: note on accepted at cycle T gives the update strobe at T+VOICES+1; a steal gives the off strobe at T+VOICES+1 and the on strobe at T+VOICES+2.
- SCAN_OFF: VOICES cycles; the first voice (lowest index) with keys_on && key_val==key is cleared.
  - On match: keys_on=0, key_val=FF, active_keys decrements, gate-off strobe in the cycle after the scan ends.
  - No match: no strobe, no state change.
  - Either way, returns to IDLE.
- ALLOFF: walks i=0..VOICES-1, emitting a gate-off strobe only for voices with keys_on=1, then sets active_keys=0. All notes off with no keys on emits no strobe.
- upd_valid is never high on two consecutive cycles except STEAL_OFF→ISSUE_ON and consecutive ALLOFF hits.
- Age counters do not change outside ISSUE_ON.
- active_keys never exceeds VOICES and never underflows.
- busy = (state != IDLE).

Decomposition:
- Shared package synth_pkg holds:
  - EV_NOTE_OFF=2'd0, EV_NOTE_ON=2'd1, EV_ALL_OFF=2'd2.
  - KEY_NONE=8'hFF.
  - The state enum for voice_scheduler.
- One natural sub-module, voice_age_tracker: holds per-voice age registers with a clear/increment/saturate rule and exposes the age vector. Free/oldest selection stays in voice_scheduler.

Test Plan:
- Reset, then note on key 60 vel 100 with all voice_free=1 → voice 0; upd_on=1, upd_key=60, upd_vel=100 at T+9; keys_on=8'h01; active_keys=1.
- Note on keys 60..67, then key 70 with voice_free=0 → off strobe for voice 0 (oldest), then on strobe for voice 0 with key 70; active_keys stays 8.
- Note on key 60 twice → second event retriggers voice 0; active_keys stays 1; no other voice gated.
- Note on key 60 then note on key 60 vel 0 → gate-off strobe voice 0, upd_key=FF; active_keys=0. A note off for key 61 afterwards produces no strobe.
- Keys 60,62,64 on, then all notes off → exactly 3 off strobes (voices 0,1,2); keys_on=0; active_keys=0.
- Assert reset_reg_N low during SCAN_ON → all outputs at reset values next edge; ev_ready=1 after release; no upd_valid emitted.
